alu_share_arbiter: RTL and testbench

Shares one combinational ALU between NREQ requesters, such as the execute stage and a branch/address-calculation unit, using round-robin arbitration. Each requester uses a valid/ready request channel and a valid/ready response channel. The block registers the granted operands, drives the shared ALU for one cycle, and captures result and flags. It then holds the response until the owning requester accepts it. The block sits between the requesters and the ALU and is the only driver of the ALU operand/op inputs.

---
 rtl/alu_share_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg / alu_share_arbiter
//
// Shares one combinational ALU between NREQ requesters using round-robin
// arbitration. A granted request has its opcode and operands registered onto
// the ALU inputs. The ALU output is captured one cycle later. The captured
// result and flags are then held on the response channel until the owning
// requester accepts them.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester request handshake (ready one-hot)
//   req_op, req_a, req_b      per-requester opcode and operands
//   rsp_valid/rsp_ready       per-requester response handshake (valid one-hot)
//   rsp_result, rsp_overflow, rsp_zero, rsp_negative
//                             captured ALU result and flags (shared)
//   alu_op, alu_a, alu_b      registered drive of the shared ALU inputs
//   alu_result, alu_overflow, alu_zero, alu_negative
//                             shared ALU outputs
//   busy                      high whenever an operation is in flight
// ---------------------------------------------------------------------------

package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_share_arbiter
  import cpu_types_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  aluop_t          req_op [NREQ],
  input  logic [31:0]     req_a  [NREQ],
  input  logic [31:0]     req_b  [NREQ],
  output logic [NREQ-1:0] rsp_valid,
  input  logic [NREQ-1:0] rsp_ready,
  output logic [31:0]     rsp_result,
  output logic            rsp_overflow,
  output logic            rsp_zero,
  output logic            rsp_negative,
  output aluop_t          alu_op,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic [31:0]     alu_result,
  input  logic            alu_overflow,
  input  logic            alu_zero,
  input  logic            alu_negative,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IDXW-1:0]   last_grant_r;
  logic [IDXW-1:0]   owner_r;
  logic [IDXW-1:0]   winner_s;
  logic              found_s;
  logic [IDXW:0]     cand_sum_s;
  logic              accept_s;

  // Round-robin search: candidates are last_grant+1, last_grant+2, ... wrapping
  // modulo NREQ; the first valid candidate wins. The extra bit of cand_sum_s
  // holds the un-wrapped sum before the modulo correction.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = '0;
    cand_sum_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum_s = {1'b0, last_grant_r} + (IDXW+1)'(k);
      if (cand_sum_s >= (IDXW+1)'(NREQ)) begin
        cand_sum_s = cand_sum_s - (IDXW+1)'(NREQ);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      if (!found_s && req_valid[cand_sum_s[IDXW-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand_sum_s[IDXW-1:0];
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // A request is taken exactly when a valid bit meets its ready bit.
  assign accept_s = |(req_valid & req_ready);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; only the owner's rsp_ready can release RESP.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready[owner_r]) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from registered state; req_ready never looks at rsp_ready.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          req_ready[winner_s] = 1'b1;
        end else begin
          req_ready = '0;
        end
      end
      ST_EXEC: busy = 1'b1;
      ST_RESP: begin
        busy               = 1'b1;
        rsp_valid[owner_r] = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Operand, ownership and response registers. The ALU drive is only
  // reloaded on an accepted request so it keeps its value between ops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant_r <= IDXW'(NREQ - 1);
      owner_r      <= '0;
      alu_op       <= ALU_SLL;
      alu_a        <= 32'h0000_0000;
      alu_b        <= 32'h0000_0000;
      rsp_result   <= 32'h0000_0000;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
    end else begin
      if (accept_s) begin
        alu_op       <= req_op[winner_s];
        alu_a        <= req_a[winner_s];
        alu_b        <= req_b[winner_s];
        owner_r      <= winner_s;
        last_grant_r <= winner_s;
      end
      if (state_r == ST_EXEC) begin
        rsp_result   <= alu_result;
        rsp_overflow <= alu_overflow;
        rsp_zero     <= alu_zero;
        rsp_negative <= alu_negative;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Directed scenarios followed by randomized traffic for alu_share_arbiter.
// A behavioural ALU drives the DUT's ALU return path. A reference model
// predicts grants with the round-robin rule and predicts results from the
// granted requester's own operands.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 2;

  logic            CLK;
  logic            RST;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  aluop_t          req_op [NREQ];
  logic [31:0]     req_a  [NREQ];
  logic [31:0]     req_b  [NREQ];
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready;
  logic [31:0]     rsp_result;
  logic            rsp_overflow, rsp_zero, rsp_negative;
  aluop_t          alu_op;
  logic [31:0]     alu_a, alu_b, alu_result;
  logic            alu_overflow, alu_zero, alu_negative;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  int last_grant;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_negative(alu_negative),
    .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural ALU: returns {overflow, result}.
  function automatic logic [32:0] alu_fn(input aluop_t op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = 32'h0;
    v = 1'b0;
    case (op)
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'd0, (a < b)};
      default:  r = 32'h0;
    endcase
    return {v, r};
  endfunction

  logic [32:0] alu_out;
  assign alu_out      = alu_fn(alu_op, alu_a, alu_b);
  assign alu_result   = alu_out[31:0];
  assign alu_overflow = alu_out[32];
  assign alu_zero     = (alu_out[31:0] == 32'h0);
  assign alu_negative = alu_out[31];

  // Round-robin reference: first valid requester after the last grant.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] o;
    o = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One full operation starting at a negedge in IDLE with inputs already set.
  // hold: cycles the owner withholds rsp_ready (non-owners assert it meanwhile).
  // valid_during: req_valid driven while the operation is in flight.
  task automatic run_op(input int hold, input logic [NREQ-1:0] valid_during);
    int              w;
    logic [NREQ-1:0] oh;
    logic [32:0]     e;
    aluop_t          eop;
    logic [31:0]     ea, eb;
    #1;
    w = rr_pick(req_valid, last_grant);
    if (w < 0) begin
      chk("idle_no_grant", 32'(req_ready), 32'd0);
      tick();
    end else begin
      oh  = onehot(w);
      eop = req_op[w];
      ea  = req_a[w];
      eb  = req_b[w];
      e   = alu_fn(eop, ea, eb);
      chk("grant", 32'(req_ready), 32'(oh));
      chk("idle_busy", 32'(busy), 32'd0);
      tick();
      req_valid = valid_during;
      #1;
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_req_ready", 32'(req_ready), 32'd0);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_alu_op", 32'(alu_op), 32'(eop));
      chk("exec_alu_a", alu_a, ea);
      chk("exec_alu_b", alu_b, eb);
      tick();
      for (int i = 0; i <= hold; i++) begin
        if (i < hold) rsp_ready = ~oh;
        else          rsp_ready = oh | NREQ'($urandom);
        #1;
        chk("resp_valid", 32'(rsp_valid), 32'(oh));
        chk("resp_result", rsp_result, e[31:0]);
        chk("resp_overflow", 32'(rsp_overflow), 32'(e[32]));
        chk("resp_zero", 32'(rsp_zero), 32'(e[31:0] == 32'h0));
        chk("resp_negative", 32'(rsp_negative), 32'(e[31]));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        chk("resp_busy", 32'(busy), 32'd1);
        tick();
      end
      last_grant = w;
      rsp_ready = '0;
      #1;
      chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_alu_a_kept", alu_a, ea);
    end
  endtask

  logic [NREQ-1:0] rr_tab [4];

  initial begin
    RST       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op[i] = ALU_SLL;
      req_a[i]  = 32'h0;
      req_b[i]  = 32'h0;
    end
    last_grant = NREQ - 1;
    repeat (3) tick();
    RST = 1'b0;
    #1;
    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_flags", {29'd0, rsp_overflow, rsp_zero, rsp_negative}, 32'd0);

    // Single op: requester 0, ADD 5+7
    req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    req_valid = 2'b01;
    run_op(0, 2'b00);
    chk("single_result_const", rsp_result, 32'd12);

    // Overflow: requester 1, ADD 7FFFFFFF+1
    req_op[1] = ALU_ADD; req_a[1] = 32'h7FFF_FFFF; req_b[1] = 32'd1;
    req_valid = 2'b10;
    run_op(0, 2'b00);
    chk("ovf_result_const", rsp_result, 32'h8000_0000);
    chk("ovf_flag_const", {30'd0, rsp_overflow, rsp_negative}, 32'd3);

    // Round-robin with both requesters continuously valid
    req_op[0] = ALU_SUB; req_a[0] = 32'd3;         req_b[0] = 32'd3;
    req_op[1] = ALU_SLT; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 32'd0;
    rr_tab[0] = 2'b01; rr_tab[1] = 2'b10; rr_tab[2] = 2'b01; rr_tab[3] = 2'b10;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_order", 32'(req_ready), 32'(rr_tab[i]));
      run_op(0, 2'b11);
      chk("rr_result_const", rsp_result, (i % 2 == 0) ? 32'd0 : 32'd1);
    end

    // Backpressure: owner (0) stalls 5 cycles while 1 stays valid
    run_op(5, 2'b11);
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b10);
    run_op(0, 2'b00);

    // Reset during EXEC of a requester-0 operation
    req_op[0] = ALU_OR; req_a[0] = 32'h1234_0000; req_b[0] = 32'h0000_5678;
    req_valid = 2'b01;
    #1;
    chk("mid_grant", 32'(req_ready), 32'b01);
    tick();
    RST = 1'b1;
    tick();
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    RST = 1'b0;
    last_grant = NREQ - 1;
    req_valid = 2'b11;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b01);
    run_op(0, 2'b00);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_op[i] = aluop_t'($urandom_range(0, 9));
        req_a[i]  = $urandom;
        req_b[i]  = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
      end
      run_op(int'($urandom_range(0, 3)), NREQ'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
